rob_flush_ctrl: RTL and testbench

Sequencer for reorder-buffer-initiated recovery. On a committed mispredict it latches the redirect target and the load/store-buffer boundary, then holds the ROB and the instruction fetcher. It broadcasts a timed flush to issuer, reservation station, ROB and register file, waits until the load/store buffer has drained committed stores, and finally redirects fetch. It sits between the ROB commit port and the flush/redirect fan-out. It also registers branch-predictor training updates.

---
 rtl/rob_flush_ctrl_pkg.sv | 28 ++
 rtl/rob_flush_perf.sv | 44 ++++
 rtl/rob_flush_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_rob_flush_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_flush_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rob_flush_ctrl_pkg
//   Shared configuration for the ROB-initiated recovery sequencer.
//   Provides:
//     REG_TYPE          - default PC width
//     LS_BUFFER_ID_TYPE - default load/store buffer entry id width
//     flush_state_e     - 2-bit recovery FSM encoding
//     fetch_held()      - true in the states that stall instruction fetch
// ----------------------------------------------------------------------------
package rob_flush_ctrl_pkg;

    localparam int REG_TYPE          = 32;
    localparam int LS_BUFFER_ID_TYPE = 4;

    typedef enum logic [1:0] {
        FLUSH_IDLE     = 2'd0,
        FLUSH_FLUSH    = 2'd1,
        FLUSH_DRAIN    = 2'd2,
        FLUSH_REDIRECT = 2'd3
    } flush_state_e;

    // Fetch stays stalled while units are being flushed and while stores
    // drain; it is released in the redirect cycle itself.
    function automatic logic fetch_held(input flush_state_e s);
        return (s == FLUSH_FLUSH) || (s == FLUSH_DRAIN);
    endfunction

endpackage

// File: rtl/rob_flush_perf.sv
// ----------------------------------------------------------------------------
// rob_flush_perf
//   Recovery performance counters, instantiated by rob_flush_ctrl only when
//   ROB_FLUSH_PERF_EN is defined. Both counters wrap modulo 2^32.
// Ports:
//   clk_in, rst_in       - clock, asynchronous active-high reset
//   flush_start_in       - one cycle per accepted mispredict (IDLE->FLUSH)
//   drain_cycle_in       - one per advancing cycle spent in DRAIN
//   flush_count          - number of recoveries started
//   drain_stall_count    - number of advancing DRAIN cycles
// ----------------------------------------------------------------------------
module rob_flush_perf (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        flush_start_in,
    input  logic        drain_cycle_in,
    output logic [31:0] flush_count,
    output logic [31:0] drain_stall_count
);

    logic [31:0] flush_count_d, flush_count_q;
    logic [31:0] drain_count_d, drain_count_q;

    always_comb begin
        flush_count_d = flush_count_q;
        drain_count_d = drain_count_q;
        if (flush_start_in) flush_count_d = flush_count_q + 32'd1;
        if (drain_cycle_in) drain_count_d = drain_count_q + 32'd1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            flush_count_q <= '0;
            drain_count_q <= '0;
        end else begin
            flush_count_q <= flush_count_d;
            drain_count_q <= drain_count_d;
        end
    end

    assign flush_count       = flush_count_q;
    assign drain_stall_count = drain_count_q;

endmodule

// File: rtl/rob_flush_ctrl.sv
// ----------------------------------------------------------------------------
// rob_flush_ctrl
//   Recovery sequencer between the ROB commit port and the flush/redirect
//   fan-out. A committed mispredict latches the redirect target and the
//   load/store boundary, broadcasts a flush for FLUSH_CYCLES cycles, waits
//   for committed stores to drain, then issues a one-cycle fetch redirect.
//   Branch commits are registered towards the predictor independently.
//
//   Optional build macro: ROB_FLUSH_PERF_EN adds flush_count and
//   drain_stall_count (via rob_flush_perf).
//
// Ports:
//   clk_in, rst_in               clock, asynchronous active-high reset
//   rdy_in                       global ready; low freezes the block
//   *_from_ro_buffer             mispredict pulse/target/boundary, branch commit
//   ls_drained_from_ls_buffer    committed stores up to dest are in memory
//   busy_to_ro_buffer            ROB must not commit
//   flush_to_units               flush to issuer, rs_station, ROB, reg_file
//   reset_to_ls_buffer           discard uncommitted LS entries
//   dest_to_ls_buffer            latched LS boundary id
//   hold/reset/next_pc_to_inst_fetcher   fetch stall, redirect pulse, target
//   *_to_br_predictor            registered training update
//   state_dbg                    current FSM state
//
// Handshake note: rdy_in acts as a global advance enable. A cycle "happens"
// only at an edge where rdy_in=1; at a frozen edge every register holds and
// the one-cycle pulses (valid_to_br_predictor, reset_to_inst_fetcher) are
// registered as 0, so a pulse is never repeated or lost across a freeze.
// br_from_ro_buffer and reset_from_ro_buffer are single-cycle valid strobes
// with no back-pressure; a mispredict outside IDLE is dropped.
// ----------------------------------------------------------------------------
module rob_flush_ctrl
    import rob_flush_ctrl_pkg::*;
#(
    parameter int REG_WIDTH    = REG_TYPE,
    parameter int LS_ID_WIDTH  = LS_BUFFER_ID_TYPE,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   reset_from_ro_buffer,
    input  logic [REG_WIDTH-1:0]   next_pc_from_ro_buffer,
    input  logic [LS_ID_WIDTH-1:0] dest_from_ro_buffer,
    input  logic                   br_from_ro_buffer,
    input  logic [REG_WIDTH-1:0]   pc_from_ro_buffer,
    input  logic                   is_taken_from_ro_buffer,
    input  logic                   ls_drained_from_ls_buffer,
    output logic                   busy_to_ro_buffer,
    output logic                   flush_to_units,
    output logic                   reset_to_ls_buffer,
    output logic [LS_ID_WIDTH-1:0] dest_to_ls_buffer,
    output logic                   hold_to_inst_fetcher,
    output logic                   reset_to_inst_fetcher,
    output logic [REG_WIDTH-1:0]   next_pc_to_inst_fetcher,
    output logic                   valid_to_br_predictor,
    output logic [REG_WIDTH-1:0]   pc_to_br_predictor,
    output logic                   is_taken_to_br_predictor,
    output flush_state_e           state_dbg
`ifdef ROB_FLUSH_PERF_EN
    ,
    output logic [31:0]            flush_count,
    output logic [31:0]            drain_stall_count
`endif
);

    // Counter width covers FLUSH_CYCLES=1 (a single bit still needed).
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);

    flush_state_e           state_d, state_q;
    logic [CNT_W-1:0]       cnt_d, cnt_q;
    logic [REG_WIDTH-1:0]   target_d, target_q;
    logic [LS_ID_WIDTH-1:0] dest_d, dest_q;
    logic                   busy_d, busy_q;
    logic                   flush_d, flush_q;
    logic                   hold_d, hold_q;
    logic                   redirect_d, redirect_q;
    logic                   br_valid_d, br_valid_q;
    logic [REG_WIDTH-1:0]   br_pc_d, br_pc_q;
    logic                   br_taken_d, br_taken_q;
    logic                   flush_start;
    logic                   drain_cycle;

    assign flush_start = rdy_in && (state_q == FLUSH_IDLE) && reset_from_ro_buffer;
    assign drain_cycle = rdy_in && (state_q == FLUSH_DRAIN);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        dest_d     = dest_q;
        br_pc_d    = br_pc_q;
        br_taken_d = br_taken_q;
        br_valid_d = 1'b0;
        redirect_d = 1'b0;

        if (rdy_in) begin
            // Training is independent of recovery: a mispredicted branch
            // committing alongside the pulse still trains.
            br_valid_d = br_from_ro_buffer;
            if (br_from_ro_buffer) begin
                br_pc_d    = pc_from_ro_buffer;
                br_taken_d = is_taken_from_ro_buffer;
            end

            unique case (state_q)
                FLUSH_IDLE: begin
                    if (reset_from_ro_buffer) begin
                        target_d = next_pc_from_ro_buffer;
                        dest_d   = dest_from_ro_buffer;
                        cnt_d    = CNT_INIT;
                        state_d  = FLUSH_FLUSH;
                    end
                end
                FLUSH_FLUSH: begin
                    if (cnt_q == '0) state_d = FLUSH_DRAIN;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                FLUSH_DRAIN: begin
                    if (ls_drained_from_ls_buffer) begin
                        state_d    = FLUSH_REDIRECT;
                        redirect_d = 1'b1;
                    end
                end
                FLUSH_REDIRECT: state_d = FLUSH_IDLE;
                default:        state_d = FLUSH_IDLE;
            endcase
        end

        // Level outputs follow the next state, so they line up with state_q
        // and simply hold through a freeze.
        busy_d  = (state_d != FLUSH_IDLE);
        flush_d = (state_d == FLUSH_FLUSH);
        hold_d  = fetch_held(state_d);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= FLUSH_IDLE;
            cnt_q      <= '0;
            target_q   <= '0;
            dest_q     <= '0;
            busy_q     <= 1'b0;
            flush_q    <= 1'b0;
            hold_q     <= 1'b0;
            redirect_q <= 1'b0;
            br_valid_q <= 1'b0;
            br_pc_q    <= '0;
            br_taken_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            dest_q     <= dest_d;
            busy_q     <= busy_d;
            flush_q    <= flush_d;
            hold_q     <= hold_d;
            redirect_q <= redirect_d;
            br_valid_q <= br_valid_d;
            br_pc_q    <= br_pc_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign busy_to_ro_buffer        = busy_q;
    assign flush_to_units           = flush_q;
    assign reset_to_ls_buffer       = flush_q;
    assign dest_to_ls_buffer        = dest_q;
    assign hold_to_inst_fetcher     = hold_q;
    assign reset_to_inst_fetcher    = redirect_q;
    assign next_pc_to_inst_fetcher  = target_q;
    assign valid_to_br_predictor    = br_valid_q;
    assign pc_to_br_predictor       = br_pc_q;
    assign is_taken_to_br_predictor = br_taken_q;
    assign state_dbg                = state_q;

`ifdef ROB_FLUSH_PERF_EN
    rob_flush_perf u_perf (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .flush_start_in    (flush_start),
        .drain_cycle_in    (drain_cycle),
        .flush_count       (flush_count),
        .drain_stall_count (drain_stall_count)
    );
`else
    // Without the counters these strobes have no consumer.
    logic unused_perf;
    assign unused_perf = flush_start ^ drain_cycle;
`endif

endmodule

// File: tb/tb_rob_flush_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rob_flush_ctrl
//   Self-checking bench for rob_flush_ctrl (default parameters). Directed
//   scenarios followed by randomized traffic, all compared every cycle
//   against a phase/countdown reference model plus a redirect-target queue.
//   Build with ROB_FLUSH_PERF_EN to also check the performance counters.
// ----------------------------------------------------------------------------
module tb_rob_flush_ctrl;

    localparam int RW = 32;
    localparam int LW = 4;
    localparam int FC = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          rdy;
    logic          rob_rst;
    logic [RW-1:0] rob_pc_tgt;
    logic [LW-1:0] rob_dest;
    logic          br;
    logic [RW-1:0] br_pc;
    logic          br_taken;
    logic          drained;
    logic          busy, flush, ls_rst, hold, redir, pv, ptaken;
    logic [LW-1:0] dest_o;
    logic [RW-1:0] next_pc_o, ppc;
    logic [1:0]    state_dbg;
`ifdef ROB_FLUSH_PERF_EN
    logic [31:0]   flush_count, drain_stall_count;
`endif

    rob_flush_ctrl #(.REG_WIDTH(RW), .LS_ID_WIDTH(LW), .FLUSH_CYCLES(FC)) dut (
        .clk_in                    (clk),
        .rst_in                    (rst),
        .rdy_in                    (rdy),
        .reset_from_ro_buffer      (rob_rst),
        .next_pc_from_ro_buffer    (rob_pc_tgt),
        .dest_from_ro_buffer       (rob_dest),
        .br_from_ro_buffer         (br),
        .pc_from_ro_buffer         (br_pc),
        .is_taken_from_ro_buffer   (br_taken),
        .ls_drained_from_ls_buffer (drained),
        .busy_to_ro_buffer         (busy),
        .flush_to_units            (flush),
        .reset_to_ls_buffer        (ls_rst),
        .dest_to_ls_buffer         (dest_o),
        .hold_to_inst_fetcher      (hold),
        .reset_to_inst_fetcher     (redir),
        .next_pc_to_inst_fetcher   (next_pc_o),
        .valid_to_br_predictor     (pv),
        .pc_to_br_predictor        (ppc),
        .is_taken_to_br_predictor  (ptaken),
        .state_dbg                 (state_dbg)
`ifdef ROB_FLUSH_PERF_EN
        ,
        .flush_count               (flush_count),
        .drain_stall_count         (drain_stall_count)
`endif
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [RW-1:0] exp_q[$];   // redirect targets still owed to fetch

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 flushing, 2 waiting for drain, 3 redirecting
    int            m_phase;
    int            m_flush_left;   // flush cycles still to be shown
    logic [RW-1:0] m_target;
    logic [LW-1:0] m_dest;
    logic          m_redir, m_pv, m_ptaken;
    logic [RW-1:0] m_ppc;
    int            m_flush_n, m_drain_n;

    task automatic model_reset();
        m_phase = 0; m_flush_left = 0;
        m_target = '0; m_dest = '0;
        m_redir = 1'b0; m_pv = 1'b0; m_ptaken = 1'b0; m_ppc = '0;
        m_flush_n = 0; m_drain_n = 0;
        exp_q.delete();
    endtask

    // Apply one clock edge worth of behaviour using the inputs present now.
    task automatic model_edge();
        m_redir = 1'b0;
        m_pv    = 1'b0;
        if (!rdy) return;
        m_pv = br;
        if (br) begin
            m_ppc    = br_pc;
            m_ptaken = br_taken;
        end
        case (m_phase)
            0: if (rob_rst) begin
                m_phase      = 1;
                m_flush_left = FC;
                m_target     = rob_pc_tgt;
                m_dest       = rob_dest;
                m_flush_n++;
                exp_q.push_back(rob_pc_tgt);
            end
            1: begin
                m_flush_left--;
                if (m_flush_left == 0) m_phase = 2;
            end
            2: begin
                m_drain_n++;
                if (drained) begin
                    m_phase = 3;
                    m_redir = 1'b1;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic compare_all();
        check_eq("busy",     busy,      m_phase != 0);
        check_eq("flush",    flush,     m_phase == 1);
        check_eq("ls_rst",   ls_rst,    m_phase == 1);
        check_eq("hold",     hold,      m_phase == 1 || m_phase == 2);
        check_eq("redir",    redir,     m_redir);
        check_eq("dest",     dest_o,    m_dest);
        check_eq("next_pc",  next_pc_o, m_target);
        check_eq("pv",       pv,        m_pv);
        check_eq("ppc",      ppc,       m_ppc);
        check_eq("ptaken",   ptaken,    m_ptaken);
        check_eq("dbg_busy", state_dbg != 2'd0, m_phase != 0);
`ifdef ROB_FLUSH_PERF_EN
        check_eq("perf_flush", flush_count,       m_flush_n);
        check_eq("perf_drain", drain_stall_count, m_drain_n);
`endif
        if (redir) begin
            if (exp_q.size() == 0) check_eq("redir_unexp", redir, 1'b0);
            else                   check_eq("redir_pc", next_pc_o, exp_q.pop_front());
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; rob_rst = 1'b0; rob_pc_tgt = '0; rob_dest = '0;
        br = 1'b0; br_pc = '0; br_taken = 1'b0; drained = 1'b1;
    endtask

    task automatic mispredict(input logic [RW-1:0] tgt, input logic [LW-1:0] d);
        rob_rst = 1'b1; rob_pc_tgt = tgt; rob_dest = d;
        step();
        rob_rst = 1'b0;
    endtask

    int busy_n, flush_n, redir_n, redir_at;
    logic [31:0] drain_base;

    // Sample one visible cycle's counters, then advance.
    task automatic count_and_step(input int k);
        if (busy)  busy_n++;
        if (flush) flush_n++;
        if (redir) begin redir_n++; redir_at = k; end
        step();
    endtask

    task automatic clear_counts();
        busy_n = 0; flush_n = 0; redir_n = 0; redir_at = -1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        model_reset();
        #12;
        compare_all();             // outputs while reset is held
        @(negedge clk);
        rst = 1'b0;
        step();

        // 1) single mispredict, drain already done
        clear_counts();
        mispredict(32'h0000_1040, 4'd5);
        for (int k = 1; k <= 8; k++) count_and_step(k);
        check_eq("t1_busy_cycles",  busy_n,   4);
        check_eq("t1_flush_cycles", flush_n,  2);
        check_eq("t1_redir_cycle",  redir_at, 4);
        check_eq("t1_dest",         dest_o,   4'd5);

        // 2) drain held off for 10 cycles in DRAIN
        clear_counts();
        drained = 1'b0;
`ifdef ROB_FLUSH_PERF_EN
        drain_base = drain_stall_count;
`else
        drain_base = '0;
`endif
        mispredict(32'h0000_5554, 4'd9);
        for (int k = 1; k <= 18; k++) begin
            drained = (k >= 13);
            count_and_step(k);
        end
        check_eq("t2_redir_cycle", redir_at, 14);
        check_eq("t2_redir_count", redir_n,  1);
`ifdef ROB_FLUSH_PERF_EN
        check_eq("t2_drain_stalls", drain_stall_count - drain_base, 32'd11);
`else
        check_eq("t2_base", drain_base, 32'd0);
`endif

        // 3) branch training in the same cycle as the mispredict
        br = 1'b1; br_pc = 32'h0000_0200; br_taken = 1'b1; drained = 1'b1;
        mispredict(32'h0000_0abc, 4'd2);
        br = 1'b0;
        check_eq("t3_pv",     pv,     1'b1);
        check_eq("t3_ppc",    ppc,    32'h200);
        check_eq("t3_ptaken", ptaken, 1'b1);
        check_eq("t3_flush",  flush,  1'b1);
        for (int k = 0; k < 6; k++) step();

        // 4) second pulse during DRAIN is ignored
        drained = 1'b0;
        mispredict(32'h0000_2abc, 4'd3);
        step(); step(); step();
        rob_rst = 1'b1; rob_pc_tgt = 32'h0000_3000; rob_dest = 4'd9;
        step();
        rob_rst = 1'b0;
        check_eq("t4_hold_pc",   next_pc_o, 32'h2abc);
        check_eq("t4_hold_dest", dest_o,    4'd3);
        drained = 1'b1;
        clear_counts();
        for (int k = 1; k <= 4; k++) count_and_step(k);
        check_eq("t4_redir_count", redir_n,   1);
        check_eq("t4_redir_pc",    next_pc_o, 32'h2abc);

        // 5) rdy low for 3 cycles during FLUSH
        clear_counts();
        mispredict(32'h0000_7000, 4'd7);
        for (int k = 1; k <= 12; k++) begin
            rdy = !(k >= 1 && k <= 3);
            count_and_step(k);
        end
        rdy = 1'b1;
        check_eq("t5_busy_cycles",  busy_n,   7);
        check_eq("t5_flush_cycles", flush_n,  5);
        check_eq("t5_redir_count",  redir_n,  1);
        check_eq("t5_redir_cycle",  redir_at, 7);

        // 6) asynchronous reset during DRAIN
        drained = 1'b0;
        mispredict(32'h0000_9990, 4'd6);
        step(); step(); step();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("t6_busy",    busy,      1'b0);
        check_eq("t6_hold",    hold,      1'b0);
        check_eq("t6_flush",   flush,     1'b0);
        check_eq("t6_ls_rst",  ls_rst,    1'b0);
        check_eq("t6_dest",    dest_o,    '0);
        check_eq("t6_next_pc", next_pc_o, '0);
        check_eq("t6_ppc",     ppc,       '0);
        rst = 1'b0;
        drained = 1'b1;
        clear_counts();
        for (int k = 1; k <= 6; k++) count_and_step(k);
        check_eq("t6_no_redir", redir_n, 0);

        // 7) randomized traffic
        for (int i = 0; i < 600; i++) begin
            rdy        = ($urandom_range(0, 7) != 0);
            rob_rst    = ($urandom_range(0, 9) == 0);
            rob_pc_tgt = $urandom() & 32'hffff_fffc;
            rob_dest   = LW'($urandom_range(0, 15));
            br         = ($urandom_range(0, 2) == 0);
            br_pc      = $urandom();
            br_taken   = 1'($urandom_range(0, 1));
            drained    = ($urandom_range(0, 3) != 0);
            step();
        end

        // let any sequence in flight complete
        idle_inputs();
        for (int k = 0; k < 12; k++) step();
        check_eq("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        n_errors++;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
